// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the cpu: streams a program image in over a valid/ready port while holding
// the cpu in reset, then serves instruction/data reads and data writes. Optional macro: CPU_MEM_WR_FWD_EN.
module cpu_mem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       instr_addr,
  output logic [DATA_W-1:0] instruction,
  input  logic [15:0]       address_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              mem_we,
  output logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  output logic              cpu_reset,
  output logic              addr_err,
  output logic              load_ovf
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CPU_AW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run_c;
  logic              load_acc_c;
  logic              ptr_at_end_c;
  logic              instr_oor_c;
  logic              data_oor_c;
  logic              cpu_wr_c;
  logic [ADDR_W-1:0] instr_idx_c;
  logic [ADDR_W-1:0] data_idx_c;

  assign run_c        = (state == S_RUN);
  assign load_acc_c   = load_valid & load_ready;
  assign ptr_at_end_c = (ptr == ADDR_W'(DEPTH - 1));
  assign instr_oor_c  = |instr_addr[CPU_AW-1:ADDR_W];
  assign data_oor_c   = |address_out[CPU_AW-1:ADDR_W];
  assign instr_idx_c  = instr_addr[ADDR_W-1:0];
  assign data_idx_c   = address_out[ADDR_W-1:0];
  assign cpu_wr_c     = run_c & mem_we & ~data_oor_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a full image (last beat or memory full) releases the cpu
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_LOAD: begin
        if (load_acc_c) begin
          state_nxt = (load_last || ptr_at_end_c) ? S_RUN : S_LOAD;
        end
      end
      S_RUN: begin
        if (reload) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load port handshake decoded from state
  always_comb begin
    load_ready = 1'b1;
    if (state == S_RUN) begin
      load_ready = 1'b0;
    end
  end

  // Load pointer, cpu reset, status flags and registered read ports
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      cpu_reset   <= 1'b1;
      load_ovf    <= 1'b0;
      addr_err    <= 1'b0;
      instruction <= '0;
      data_in     <= '0;
    end else begin
      if (run_c && reload) begin
        ptr <= '0;
      end else if (load_acc_c) begin
        ptr <= ptr + ADDR_W'(1);
      end

      cpu_reset <= (state_nxt != S_RUN);

      if (load_acc_c && ptr_at_end_c && !load_last) begin
        load_ovf <= 1'b1;
      end

      addr_err    <= run_c & (instr_oor_c | data_oor_c);
      instruction <= (run_c && !instr_oor_c) ? mem[instr_idx_c] : '0;
`ifdef CPU_MEM_WR_FWD_EN
      if (cpu_wr_c) begin
        data_in <= data_out;
      end else begin
        data_in <= (run_c && !data_oor_c) ? mem[data_idx_c] : '0;
      end
`else
      data_in     <= (run_c && !data_oor_c) ? mem[data_idx_c] : '0;
`endif
    end
  end

  // Single write port: image beats while loading, cpu stores while running
  always_ff @(posedge clk) begin
    if (load_acc_c) begin
      mem[ptr] <= load_data;
    end else if (cpu_wr_c) begin
      mem[data_idx_c] <= data_out;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus randomized loads and cpu traffic
// checked every cycle against a word-level behavioural model.
module tb_cpu_mem_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr_addr;
  logic [15:0] instruction;
  logic [15:0] address_out;
  logic [15:0] data_out;
  logic        mem_we;
  logic [15:0] data_in;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;
  logic        reload;
  logic        cpu_reset;
  logic        addr_err;
  logic        load_ovf;

  cpu_mem_responder #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_addr (instr_addr),
    .instruction(instruction),
    .address_out(address_out),
    .data_out   (data_out),
    .mem_we     (mem_we),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .reload     (reload),
    .cpu_reset  (cpu_reset),
    .addr_err   (addr_err),
    .load_ovf   (load_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: image word count, running flag, word array with defined-ness
  logic [15:0] mm  [DEPTH];
  bit          vld [DEPTH];
  bit          running;
  int          cnt;
  bit          ovf;
  logic [15:0] exp_instr;
  bit          exp_instr_k;
  logic [15:0] exp_data;
  bit          exp_data_k;
  bit          exp_err;
  bit          fwd_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    running     = 1'b0;
    cnt         = 0;
    ovf         = 1'b0;
    exp_instr   = '0;
    exp_instr_k = 1'b1;
    exp_data    = '0;
    exp_data_k  = 1'b1;
    exp_err     = 1'b0;
    for (int i = 0; i < DEPTH; i++) vld[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit i_oor, d_oor;
    int ia, da;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (running) begin
      i_oor = (instr_addr >= 16'(DEPTH));
      d_oor = (address_out >= 16'(DEPTH));
      ia = int'(instr_addr) % DEPTH;
      da = int'(address_out) % DEPTH;
      exp_err = i_oor || d_oor;
      if (i_oor) begin
        exp_instr = '0; exp_instr_k = 1'b1;
      end else begin
        exp_instr = mm[ia]; exp_instr_k = vld[ia];
      end
      if (d_oor) begin
        exp_data = '0; exp_data_k = 1'b1;
      end else if (fwd_en && mem_we) begin
        exp_data = data_out; exp_data_k = 1'b1;
      end else begin
        exp_data = mm[da]; exp_data_k = vld[da];
      end
      if (mem_we && !d_oor) begin
        mm[da] = data_out; vld[da] = 1'b1;
      end
      if (reload) begin
        running = 1'b0; cnt = 0;
      end
    end else begin
      exp_instr = '0; exp_instr_k = 1'b1;
      exp_data  = '0; exp_data_k  = 1'b1;
      exp_err   = 1'b0;
      if (load_valid) begin
        mm[cnt] = load_data; vld[cnt] = 1'b1;
        cnt++;
        if (load_last || cnt == DEPTH) begin
          running = 1'b1;
          if (!load_last) ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    if (exp_instr_k) chk("instruction", 32'(instruction), 32'(exp_instr));
    if (exp_data_k)  chk("data_in", 32'(data_in), 32'(exp_data));
    chk("addr_err",   32'(addr_err),   32'(exp_err));
    chk("cpu_reset",  32'(cpu_reset),  32'(!running));
    chk("load_ready", 32'(load_ready), 32'(!running));
    chk("load_ovf",   32'(load_ovf),   32'(ovf));
  endtask

  // One clock: model samples inputs at the edge, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return {8'($urandom_range(1, 255)), 8'($urandom)};
    if (r < 9)  return 16'($urandom_range(0, 15));
    return 16'($urandom_range(0, 255));
  endfunction

  task automatic run_traffic(input int n);
    reload = 1'b0;
    for (int i = 0; i < n; i++) begin
      instr_addr  = pick_addr();
      address_out = pick_addr();
      mem_we      = 1'($urandom_range(0, 1));
      data_out    = 16'($urandom);
      load_valid  = 1'($urandom_range(0, 1));
      load_data   = 16'($urandom);
      load_last   = 1'($urandom_range(0, 1));
      step();
    end
    mem_we = 1'b0; load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic load_image(input int n, input bit with_last);
    int acc;
    int guard;
    acc = 0;
    guard = 0;
    while (acc < n && guard < 4 * n + 20) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = 16'($urandom);
      load_last  = with_last && (acc == n - 1);
      step();
      if (load_valid) acc++;
      guard++;
    end
    chk("load_image_beats", 32'(acc), 32'(n));
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d, input bit last);
    load_valid = 1'b1; load_data = d; load_last = last;
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CPU_MEM_WR_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    reset_n = 1'b0;
    instr_addr = '0; address_out = '0; data_out = '0; mem_we = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; reload = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_cpu_reset",   32'(cpu_reset),   32'd1);
    chk("rst_load_ready",  32'(load_ready),  32'd1);
    chk("rst_instruction", 32'(instruction), 32'd0);
    chk("rst_data_in",     32'(data_in),     32'd0);
    chk("rst_load_ovf",    32'(load_ovf),    32'd0);
    chk("rst_addr_err",    32'(addr_err),    32'd0);
    reset_n = 1'b1;
    step();

    // Three-beat image, cpu released after the last beat
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    chk("load_cpu_reset_held", 32'(cpu_reset), 32'd1);
    beat(16'h3333, 1'b1);
    chk("load_cpu_reset_fall", 32'(cpu_reset),  32'd0);
    chk("load_ready_run",      32'(load_ready), 32'd0);
    instr_addr = 16'd2;
    step();
    chk("fetch_addr2", 32'(instruction), 32'h3333);

    mem_we = 1'b1; address_out = 16'd5; data_out = 16'hBEEF;
    step();
    mem_we = 1'b0;
    step();
    chk("read_back_5", 32'(data_in), 32'hBEEF);

    mem_we = 1'b1; data_out = 16'hAAAA;
    step();
    chk("rdw_addr5", 32'(data_in), fwd_en ? 32'hAAAA : 32'hBEEF);

    address_out = 16'h0100; data_out = 16'h5A5A;
    step();
    chk("oor_data_in",  32'(data_in),  32'd0);
    chk("oor_addr_err", 32'(addr_err), 32'd1);
    mem_we = 1'b0; address_out = 16'd0;
    step();
    chk("oor_err_pulse", 32'(addr_err), 32'd0);
    chk("oor_mem0_kept", 32'(data_in),  32'h1111);

    run_traffic(150);
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("reload_cpu_reset",  32'(cpu_reset),  32'd1);
    chk("reload_load_ready", 32'(load_ready), 32'd1);

    for (int r = 0; r < 3; r++) begin
      load_image($urandom_range(1, 20), 1'b1);
      run_traffic(80);
      reload = 1'b1;
      step();
      reload = 1'b0;
    end

    // Image without a last beat fills memory and overflows
    load_image(DEPTH, 1'b0);
    chk("ovf_flag",       32'(load_ovf),   32'd1);
    chk("ovf_load_ready", 32'(load_ready), 32'd0);
    chk("ovf_cpu_reset",  32'(cpu_reset),  32'd0);
    run_traffic(60);
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("ovf_sticky", 32'(load_ovf), 32'd1);

    // Reset in the middle of a load
    beat(16'h0A0A, 1'b0);
    beat(16'h0B0B, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_cpu_reset",  32'(cpu_reset),  32'd1);
    chk("midrst_load_ready", 32'(load_ready), 32'd1);
    chk("midrst_load_ovf",   32'(load_ovf),   32'd0);
    step();
    reset_n = 1'b1;
    beat(16'hCAFE, 1'b0);
    beat(16'hD00D, 1'b0);
    beat(16'hF00D, 1'b1);
    instr_addr = 16'd0; address_out = 16'd2;
    step();
    chk("midrst_ptr_zero", 32'(instruction), 32'hCAFE);
    chk("midrst_word2",    32'(data_in),     32'hF00D);
    run_traffic(40);
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("final_reload_cpu_reset", 32'(cpu_reset),  32'd1);
    chk("final_reload_ready",     32'(load_ready), 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
